// File: rtl/cpu_run_ctrl.sv
// Load/run/dump sequencer for the pipelined MIPS core: streams a program into instruction RAM,
// runs it until the halt word has drained, then dumps the register file. Optional watchdog: RUN_WATCHDOG_EN.
module cpu_run_ctrl #(
    parameter int          ADDR_W       = 6,
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
    parameter logic [31:0] MAX_CYCLES   = 32'd100000
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              cpu_run,
    input  logic [31:0]       if_instr,
    output logic [4:0]        rf_raddr,
    input  logic [31:0]       rf_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [4:0]        dump_idx,
    output logic [31:0]       dump_data,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DUMP,
        S_DONE
    } state_t;

    // DRAIN_CYCLES is assumed to be at least 1.
    localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    state_t            state_reg,   state_next;
    logic [ADDR_W-1:0] ptr_reg,     ptr_next;
    logic [4:0]        idx_reg,     idx_next;
    logic [31:0]       cyc_reg,     cyc_next;
    logic [DW-1:0]     drain_reg,   drain_next;
    logic              timeout_reg, timeout_next;
    logic [31:0]       cyc_inc;
    logic              wd_hit;

    assign cyc_inc = (cyc_reg == 32'hFFFF_FFFF) ? cyc_reg : cyc_reg + 32'd1;

`ifdef RUN_WATCHDOG_EN
    // Fires on the cycle whose count reaches the limit, so DUMP sees exactly MAX_CYCLES.
    assign wd_hit = (cyc_inc >= MAX_CYCLES);
`else
    logic unused_max;
    assign unused_max = ^MAX_CYCLES;
    assign wd_hit     = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg   <= S_IDLE;
            ptr_reg     <= '0;
            idx_reg     <= '0;
            cyc_reg     <= '0;
            drain_reg   <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            idx_reg     <= idx_next;
            cyc_reg     <= cyc_next;
            drain_reg   <= drain_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        idx_next     = idx_reg;
        cyc_next     = cyc_reg;
        drain_next   = drain_reg;
        timeout_next = timeout_reg;
        load_ready   = 1'b0;
        imem_we      = 1'b0;
        imem_wdata   = '0;
        cpu_rst      = 1'b0;
        cpu_run      = 1'b0;
        dump_valid   = 1'b0;
        dump_data    = '0;
        busy         = 1'b1;
        done         = 1'b0;

        case (state_reg)
            S_IDLE, S_DONE: begin
                busy    = 1'b0;
                done    = (state_reg == S_DONE);
                cpu_rst = (state_reg == S_IDLE);
                if (start) begin
                    state_next   = S_LOAD;
                    ptr_next     = '0;
                    idx_next     = '0;
                    cyc_next     = '0;
                    timeout_next = 1'b0;
                end
            end
            S_LOAD: begin
                cpu_rst    = 1'b1;
                load_ready = 1'b1;
                imem_we    = load_valid;
                imem_wdata = load_data;
                if (load_valid) begin
                    ptr_next = ptr_reg + ADDR_W'(1);
                    if (load_last || (ptr_reg == '1)) begin
                        state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                cpu_run  = 1'b1;
                cyc_next = cyc_inc;
                if (wd_hit) begin
                    state_next   = S_DUMP;
                    timeout_next = 1'b1;
                end else if (if_instr == HALT_WORD) begin
                    state_next = S_DRAIN;
                    drain_next = '0;
                end
            end
            S_DRAIN: begin
                cpu_run  = 1'b1;
                cyc_next = cyc_inc;
                if (wd_hit) begin
                    state_next   = S_DUMP;
                    timeout_next = 1'b1;
                end else if (drain_reg == DRAIN_LAST) begin
                    state_next = S_DUMP;
                end else begin
                    drain_next = drain_reg + DW'(1);
                end
            end
            S_DUMP: begin
                dump_valid = 1'b1;
                dump_data  = rf_rdata;
                if (dump_ready) begin
                    idx_next = idx_reg + 5'd1;
                    if (idx_reg == 5'd31) begin
                        state_next = S_DONE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign imem_addr   = ptr_reg;
    assign rf_raddr    = idx_reg;
    assign dump_idx    = idx_reg;
    assign timeout     = timeout_reg;
    assign cycle_count = cyc_reg;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a fetch/register-file stand-in for the core plus randomized
// load, run and dump traffic checked against program-level expectations.
module tb_cpu_run_ctrl;

    localparam int          DRAIN = 4;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
`ifdef RUN_WATCHDOG_EN
    localparam logic [31:0] TB_MAX = 32'd50;
`else
    localparam logic [31:0] TB_MAX = 32'd100000;
`endif

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        start = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        cpu_run;
    logic [31:0] if_instr;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] cycle_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] imem_m [64] = '{default: 32'h0};
    logic [31:0] rf_m [32];
    logic [31:0] exp_words [64];
    logic [5:0]  pc = '0;
    logic [31:0] last_cnt;

    always #5 CLK = ~CLK;

    cpu_run_ctrl #(
        .ADDR_W(6), .DRAIN_CYCLES(DRAIN), .HALT_WORD(HALT), .MAX_CYCLES(TB_MAX)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .start(start),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .cpu_run(cpu_run), .if_instr(if_instr),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
        .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
    );

    // Core stand-in: instruction RAM, a PC held by cpu_rst and advanced by cpu_run.
    always @(posedge CLK) begin
        if (imem_we) imem_m[imem_addr] <= imem_wdata;
        if (cpu_rst) pc <= '0;
        else if (cpu_run) pc <= pc + 6'd1;
    end
    assign if_instr = imem_m[pc];
    assign rf_rdata = rf_m[rf_raddr];

    task automatic pulse_start();
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        total++;
        if (load_ready !== 1'b1 || cpu_rst !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
            timeout !== 1'b0 || cycle_count !== 32'd0)
            begin bad++; $display("FAIL start_to_load ready=%b rst=%b busy=%b done=%b to=%b cnt=%0d need 1 1 1 0 0 0",
                load_ready, cpu_rst, busy, done, timeout, cycle_count); end
    endtask

    task automatic do_load(input int n, input bit use_last, input int halt_at, input bit fixed);
        int idx = 0;
        int ptr = 0;
        int guard = 0;
        bit v;
        if (!fixed)
            for (int i = 0; i < n; i++)
                exp_words[i] = (i == halt_at) ? HALT : ($urandom() & 32'h7FFF_FFFF);
        while (idx < n && guard < 1000) begin
            @(negedge CLK); guard++;
            v = ($urandom_range(0, 3) != 0);
            load_valid = v;
            load_data  = exp_words[idx];
            load_last  = use_last && (idx == n - 1);
            #1;
            total++;
            if (load_ready !== 1'b1 || imem_we !== v)
                begin bad++; $display("FAIL load_hs idx=%0d ready=%b we=%b need ready=1 we=%b", idx, load_ready, imem_we, v); end
            if (v) begin
                total++;
                if (imem_addr !== 6'(ptr) || imem_wdata !== exp_words[idx])
                    begin bad++; $display("FAIL load_write addr=%0d data=%h need addr=%0d data=%h",
                        imem_addr, imem_wdata, ptr, exp_words[idx]); end
                idx++; ptr++;
            end
        end
        total++;
        if (idx < n) begin bad++; $display("FAIL load_timeout accepted=%0d need %0d", idx, n); end
        @(negedge CLK);
        load_valid = 1'b0; load_last = 1'b0; load_data = '0;
        total++;
        if ({cpu_rst, cpu_run, load_ready} !== 3'b010)
            begin bad++; $display("FAIL run_entry rst/run/ready=%b need 010", {cpu_rst, cpu_run, load_ready}); end
        for (int i = 0; i < n; i++) begin
            total++;
            if (imem_m[i] !== exp_words[i])
                begin bad++; $display("FAIL imem_content addr=%0d got=%h need=%h", i, imem_m[i], exp_words[i]); end
        end
        $display("load: %0d words, last=%b", n, use_last);
    endtask

    task automatic do_run(input int exp_cyc, input logic [31:0] exp_cnt, input bit exp_to);
        int cyc = 1;
        while (dump_valid !== 1'b1 && cyc < 2000) begin
            start = ($urandom_range(0, 4) == 0);
            @(negedge CLK); cyc++;
        end
        start = 1'b0;
        total++;
        if (cyc !== exp_cyc) begin bad++; $display("FAIL dump_latency got=%0d need=%0d", cyc, exp_cyc); end
        total++;
        if (cycle_count !== exp_cnt) begin bad++; $display("FAIL cycle_count got=%0d need=%0d", cycle_count, exp_cnt); end
        total++;
        if (timeout !== exp_to) begin bad++; $display("FAIL timeout got=%b need=%b", timeout, exp_to); end
        total++;
        if (cpu_run !== 1'b0 || cpu_rst !== 1'b0 || busy !== 1'b1)
            begin bad++; $display("FAIL dump_freeze run=%b rst=%b busy=%b need 0 0 1", cpu_run, cpu_rst, busy); end
        last_cnt = exp_cnt;
        $display("run: dump after %0d cycles, count=%0d", cyc, cycle_count);
    endtask

    task automatic do_dump(input int stop_at, input bit pattern);
        logic [3:0] pat;
        int e = 0;
        int b = 0;
        int guard = 0;
        bit rdy;
        pat = 4'b1001;
        while (e < stop_at && guard < 1000) begin
            guard++;
            rdy = (pattern && b < 4) ? pat[3 - b] : ($urandom_range(0, 2) != 0);
            dump_ready = rdy;
            #1;
            total++;
            if (dump_valid !== 1'b1 || dump_idx !== 5'(e) || dump_data !== rf_m[e])
                begin bad++; $display("FAIL dump_beat valid=%b idx=%0d data=%h need 1 idx=%0d data=%h",
                    dump_valid, dump_idx, dump_data, e, rf_m[e]); end
            @(negedge CLK);
            if (rdy) e++;
            b++;
        end
        dump_ready = 1'b0;
        total++;
        if (e < stop_at) begin bad++; $display("FAIL dump_timeout beats=%0d need %0d", e, stop_at); end
        if (stop_at == 32) begin
            total++;
            if (done !== 1'b1 || dump_valid !== 1'b0 || busy !== 1'b0 || cpu_run !== 1'b0 || cpu_rst !== 1'b0)
                begin bad++; $display("FAIL done_state done=%b valid=%b busy=%b run=%b rst=%b need 1 0 0 0 0",
                    done, dump_valid, busy, cpu_run, cpu_rst); end
            total++;
            if (cycle_count !== last_cnt)
                begin bad++; $display("FAIL count_frozen got=%0d need=%0d", cycle_count, last_cnt); end
        end
        $display("dump: %0d beats in %0d cycles", e, b);
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if (cpu_rst !== 1'b1 || {cpu_run, load_ready, imem_we, dump_valid, busy, done, timeout} !== 7'b0)
            begin bad++; $display("FAIL %s_ctrl rst=%b run/rdy/we/val/busy/done/to=%b need 1 0000000", tag, cpu_rst,
                {cpu_run, load_ready, imem_we, dump_valid, busy, done, timeout}); end
        total++;
        if (imem_addr !== 6'd0 || dump_idx !== 5'd0 || rf_raddr !== 5'd0 || dump_data !== 32'd0 || cycle_count !== 32'd0)
            begin bad++; $display("FAIL %s_data addr=%0d idx=%0d raddr=%0d data=%h cnt=%0d need all 0", tag,
                imem_addr, dump_idx, rf_raddr, dump_data, cycle_count); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        check_reset_values("reset");
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
        check_reset_values("idle");
        $display("reset: checked");
    endtask

    task automatic test_program();
        for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
        rf_m[1] = 32'h5;
        rf_m[2] = 32'hC;
        exp_words[0] = 32'h2001_0005;
        exp_words[1] = 32'h2022_0007;
        exp_words[2] = HALT;
        pulse_start();
        do_load(3, 1'b1, 2, 1'b1);
        do_run(2 + DRAIN + 2, 32'(2 + 1 + DRAIN), 1'b0);
        do_dump(32, 1'b1);
    endtask

    task automatic test_random();
        int n;
        int h;
        repeat (4) begin
            n = $urandom_range(1, 12);
            h = $urandom_range(0, n - 1);
            for (int i = 0; i < 32; i++) rf_m[i] = $urandom();
            pulse_start();
            do_load(n, 1'b1, h, 1'b0);
            do_run(h + DRAIN + 2, 32'(h + 1 + DRAIN), 1'b0);
            do_dump(32, 1'b0);
        end
    endtask

    task automatic test_reset_mid_dump();
        for (int i = 0; i < 32; i++) rf_m[i] = $urandom();
        pulse_start();
        do_load(3, 1'b1, 1, 1'b0);
        do_run(1 + DRAIN + 2, 32'(1 + 1 + DRAIN), 1'b0);
        do_dump(10, 1'b0);
        #2 RESET_N = 1'b0;
        #1 check_reset_values("async_reset");
        @(negedge CLK); RESET_N = 1'b1;
        pulse_start();
        do_load(2, 1'b1, 1, 1'b0);
        do_run(1 + DRAIN + 2, 32'(1 + 1 + DRAIN), 1'b0);
        do_dump(32, 1'b0);
    endtask

`ifdef RUN_WATCHDOG_EN
    task automatic test_watchdog();
        for (int i = 0; i < 32; i++) rf_m[i] = $urandom();
        pulse_start();
        do_load(16, 1'b1, -1, 1'b0);
        do_run(51, 32'd50, 1'b1);
        do_dump(32, 1'b0);
        pulse_start();
        do_load(1, 1'b1, 0, 1'b0);
        do_run(DRAIN + 2, 32'(1 + DRAIN), 1'b0);
        do_dump(32, 1'b0);
    endtask
`endif

    task automatic test_fill();
        for (int i = 0; i < 32; i++) rf_m[i] = $urandom();
        pulse_start();
        do_load(64, 1'b0, 5, 1'b0);
        do_run(5 + DRAIN + 2, 32'(5 + 1 + DRAIN), 1'b0);
        do_dump(32, 1'b0);
    endtask

    initial begin
        test_reset();
        test_program();
        test_random();
        test_reset_mid_dump();
`ifdef RUN_WATCHDOG_EN
        test_watchdog();
`endif
        test_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
